// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_pkg
// Description : Shared types, constants and helpers for the Ethernet receive
//               decapsulator (FIFO word format, FSM encoding, keep helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

    // 74-bit FIFO word: [73] user, [72] last, [71:64] keep, [63:0] data.
    // Same layout as the transmit-direction FIFO so both paths share tooling.
    typedef struct packed {
        logic        user;
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } fifo_word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR1    = 3'd1,
        PAYLOAD = 3'd2,
        FLUSH   = 3'd3,
        DISCARD = 3'd4
    } state_t;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_BYTES = 14;

    // Contiguous byte-enable mask with the n lowest bytes set (n = 0..8).
    function automatic logic [7:0] keep_lsb(input logic [3:0] n);
        logic [7:0] k;
        for (int i = 0; i < 8; i++) begin
            k[i] = (4'(i) < n);
        end
        return k;
    endfunction

    // Number of valid bytes in a word; tkeep is contiguous so this is the
    // byte count of the word.
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, k[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_hdr_match.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_hdr_match
// Description : Ethernet header filter. Compares the destination MAC on the
//               first word (registered into dst_ok) and the EtherType on the
//               second word (combinational).
// Ports       : clk156, sys_rst_n  - clock / async active-low reset
//               dst_load           - first word of a frame is on hdr_bytes
//               hdr_bytes[47:0]    - bytes 0..5 of the current rx word
//               dst_ok             - registered destination-accept flag
//               etype_match        - EtherType of current word matches
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_hdr_match
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] MY_MAC       = 48'h00_11_22_33_44_55,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        dst_load,
    input  logic [47:0] hdr_bytes,
    output logic        dst_ok,
    output logic        etype_match
);

    logic [47:0] w_dst;
    logic [15:0] w_etype;
    logic        w_dst_match;
    logic        r_dst_ok;

    // Wire byte 0 lands in tdata[7:0]; the MAC constant is written in
    // network order, so byte 0 is its most significant byte.
    assign w_dst = {hdr_bytes[7:0],   hdr_bytes[15:8],  hdr_bytes[23:16],
                    hdr_bytes[31:24], hdr_bytes[39:32], hdr_bytes[47:40]};

    // EtherType sits in bytes 4 (high) and 5 (low) of the second word.
    assign w_etype = {hdr_bytes[39:32], hdr_bytes[47:40]};

    assign w_dst_match = (w_dst == MY_MAC) ||
                         (ACCEPT_BCAST && (w_dst == BCAST_MAC));

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dst_ok <= 1'b0;
        end else if (dst_load) begin
            r_dst_ok <= w_dst_match;
        end
    end

    assign dst_ok      = r_dst_ok;
    assign etype_match = (w_etype == ETHERTYPE);

endmodule
`default_nettype wire

// File: rtl/eth_rx_decap.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_decap
// Description : 10G MAC receive decapsulator. Filters frames on destination
//               MAC and EtherType, strips the 14-byte header, realigns the
//               payload to byte 0 and writes 74-bit words into the
//               eth-to-PCIe async FIFO.
// Ports       : clk156, sys_rst_n     - clock / async active-low reset
//               s_axis_rx_*           - MAC rx stream (no back-pressure)
//               full, almost_full     - FIFO status
//               wr_en, din[73:0]      - FIFO write port
//               rx_ok_cnt             - frames forwarded
//               rx_drop_cnt           - frames filtered or refused
//               rx_ovf_cnt            - words lost to FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_decap
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] MY_MAC       = 48'h00_11_22_33_44_55,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    input  logic        full,
    input  logic        almost_full,
    output logic        wr_en,
    output logic [73:0] din,
    output logic [31:0] rx_ok_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic [31:0] rx_ovf_cnt
);

    state_t      r_state;
    logic [15:0] r_prev_hi;     // bytes 6..7 of the previous input word
    logic [3:0]  r_last_n;      // byte count of the last word, for FLUSH
    logic        r_last_user;   // FCS status held across FLUSH
    logic        r_ovf;         // a word of this frame was lost to full
    logic        r_wr_pend;     // din holds a word to be written this cycle
    fifo_word_t  r_din;
    logic [31:0] r_ok_cnt;
    logic [31:0] r_drop_cnt;
    logic [31:0] r_ovf_cnt;

    logic        w_dst_load;
    logic        w_dst_ok;
    logic        w_etype_match;
    logic        w_accept;
    logic        w_blocked;
    logic        w_ovf_now;
    logic [3:0]  w_n;
    logic [63:0] w_realign;
    logic        w_req;
    logic        w_final;
    fifo_word_t  w_word;

    eth_rx_hdr_match #(
        .MY_MAC       (MY_MAC),
        .ETHERTYPE    (ETHERTYPE),
        .ACCEPT_BCAST (ACCEPT_BCAST)
    ) u_hdr_match (
        .clk156      (clk156),
        .sys_rst_n   (sys_rst_n),
        .dst_load    (w_dst_load),
        .hdr_bytes   (s_axis_rx_tdata[47:0]),
        .dst_ok      (w_dst_ok),
        .etype_match (w_etype_match)
    );

    assign w_dst_load = (r_state == IDLE) && s_axis_rx_tvalid;
    assign w_accept   = w_dst_ok && w_etype_match && !almost_full;
    assign w_n        = popcount8(s_axis_rx_tkeep);

    // Output word k = {in(k+2)[47:0], in(k+1)[63:48]}.
    assign w_realign = {s_axis_rx_tdata[47:0], r_prev_hi};

    // The write decided last cycle is gated by full in the cycle it would
    // reach the FIFO, so wr_en can never coincide with full.
    assign w_blocked = r_wr_pend && full;

    // Include a word being blocked right now so the final word of the frame
    // is marked bad even when the loss happens on the preceding word.
    assign w_ovf_now = r_ovf || w_blocked;

    // Datapath decode: which word (if any) the current cycle produces.
    always_comb begin
        w_req   = 1'b0;
        w_final = 1'b0;
        w_word  = '0;
        case (r_state)
            HDR1: begin
                // Short frame whose only payload is in bytes 6..7 of word 1.
                if (s_axis_rx_tvalid && s_axis_rx_tlast && w_accept &&
                    (w_n > 4'd6)) begin
                    w_req       = 1'b1;
                    w_final     = 1'b1;
                    w_word.data = {48'b0, s_axis_rx_tdata[63:48]};
                    w_word.keep = keep_lsb(w_n - 4'd6);
                    w_word.last = 1'b1;
                    w_word.user = s_axis_rx_tuser && !w_ovf_now;
                end
            end
            PAYLOAD: begin
                if (s_axis_rx_tvalid) begin
                    w_req       = 1'b1;
                    w_word.data = w_realign;
                    if (s_axis_rx_tlast && (w_n <= 4'd6)) begin
                        // Tail fits together with the carried two bytes.
                        w_final     = 1'b1;
                        w_word.keep = keep_lsb(w_n + 4'd2);
                        w_word.last = 1'b1;
                        w_word.user = s_axis_rx_tuser && !w_ovf_now;
                    end else begin
                        w_word.keep = 8'hFF;
                    end
                end
            end
            FLUSH: begin
                // Emit the 1..2 bytes left over from the last input word.
                w_req       = 1'b1;
                w_final     = 1'b1;
                w_word.data = {48'b0, r_prev_hi};
                w_word.keep = keep_lsb(r_last_n - 4'd6);
                w_word.last = 1'b1;
                w_word.user = r_last_user && !w_ovf_now;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_prev_hi   <= 16'h0000;
            r_last_n    <= 4'd0;
            r_last_user <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_din       <= '0;
            r_ok_cnt    <= 32'd0;
            r_drop_cnt  <= 32'd0;
            r_ovf_cnt   <= 32'd0;
        end else begin
            if (w_blocked) begin
                r_ovf     <= 1'b1;
                r_ovf_cnt <= r_ovf_cnt + 32'd1;
            end

            r_wr_pend <= w_req;
            if (w_req) begin
                r_din <= w_word;
            end

            // A frame counts as forwarded even if words were lost to full.
            if (w_final) begin
                r_ok_cnt <= r_ok_cnt + 32'd1;
            end

            if (s_axis_rx_tvalid) begin
                r_prev_hi <= s_axis_rx_tdata[63:48];
            end

            case (r_state)
                IDLE: begin
                    if (s_axis_rx_tvalid) begin
                        // New frame: forget any loss from the previous one.
                        r_ovf <= 1'b0;
                        if (s_axis_rx_tlast) begin
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                        end else begin
                            r_state <= HDR1;
                        end
                    end
                end
                HDR1: begin
                    if (s_axis_rx_tvalid) begin
                        if (!w_accept) begin
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                            r_state    <= s_axis_rx_tlast ? IDLE : DISCARD;
                        end else if (s_axis_rx_tlast) begin
                            if (w_n <= 4'd6) begin
                                r_drop_cnt <= r_drop_cnt + 32'd1;
                            end
                            r_state <= IDLE;
                        end else begin
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
                        if (w_n <= 4'd6) begin
                            r_state <= IDLE;
                        end else begin
                            r_last_n    <= w_n;
                            r_last_user <= s_axis_rx_tuser;
                            r_state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_state <= IDLE;
                end
                DISCARD: begin
                    if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_en       = r_wr_pend && !full;
    assign din         = r_din;
    assign rx_ok_cnt   = r_ok_cnt;
    assign rx_drop_cnt = r_drop_cnt;
    assign rx_ovf_cnt  = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_decap.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_decap
// Description : Directed self-checking bench for eth_rx_decap. Builds frames
//               byte by byte, predicts the realigned FIFO words and counters,
//               and compares them with what the DUT writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_decap;

    localparam logic [47:0] C_MY_MAC = 48'h00_11_22_33_44_55;
    localparam logic [47:0] C_BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] C_ETYPE  = 16'h88B5;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic        rx_tvalid;
    logic [63:0] rx_tdata;
    logic [7:0]  rx_tkeep;
    logic        rx_tlast;
    logic        rx_tuser;
    logic        full;
    logic        almost_full;
    logic        wr_en;
    logic [73:0] din;
    logic [31:0] rx_ok_cnt, rx_drop_cnt, rx_ovf_cnt;
    logic        nb_wr_en;
    logic [73:0] nb_din;
    logic [31:0] nb_ok_cnt, nb_drop_cnt, nb_ovf_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_ok, exp_drop, exp_ovf;
    int          viol = 0;
    logic [73:0] q_got[$];
    logic [73:0] q_exp[$];
    logic [7:0]  fr[0:255];

    always #3 clk156 = ~clk156;

    eth_rx_decap #(
        .MY_MAC(C_MY_MAC), .ETHERTYPE(C_ETYPE), .ACCEPT_BCAST(1'b1)
    ) dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .s_axis_rx_tvalid(rx_tvalid), .s_axis_rx_tdata(rx_tdata),
        .s_axis_rx_tkeep(rx_tkeep), .s_axis_rx_tlast(rx_tlast),
        .s_axis_rx_tuser(rx_tuser), .full(full), .almost_full(almost_full),
        .wr_en(wr_en), .din(din), .rx_ok_cnt(rx_ok_cnt),
        .rx_drop_cnt(rx_drop_cnt), .rx_ovf_cnt(rx_ovf_cnt)
    );

    // Same stream, broadcast acceptance disabled.
    eth_rx_decap #(
        .MY_MAC(C_MY_MAC), .ETHERTYPE(C_ETYPE), .ACCEPT_BCAST(1'b0)
    ) dut_nb (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .s_axis_rx_tvalid(rx_tvalid), .s_axis_rx_tdata(rx_tdata),
        .s_axis_rx_tkeep(rx_tkeep), .s_axis_rx_tlast(rx_tlast),
        .s_axis_rx_tuser(rx_tuser), .full(full), .almost_full(almost_full),
        .wr_en(nb_wr_en), .din(nb_din), .rx_ok_cnt(nb_ok_cnt),
        .rx_drop_cnt(nb_drop_cnt), .rx_ovf_cnt(nb_ovf_cnt)
    );

    always @(negedge clk156) begin
        if (wr_en) q_got.push_back(din);
        if (wr_en && full) viol++;
    end

    task automatic check(input string tag, input logic [73:0] got,
                         input logic [73:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] kmask(input int n);
        logic [7:0] k;
        for (int i = 0; i < 8; i++) k[i] = (i < n);
        return k;
    endfunction

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
            rx_tkeep = 8'h00; rx_tdata = 64'h0; full = 1'b0; almost_full = 1'b0;
        end
    endtask

    // fwd: frame expected to be forwarded. ovf_at: full held while input
    // words ovf_at and ovf_at+1 are presented (-1 = never). gap_at: one idle
    // cycle before that word. rst_at: reset asserted instead of that word.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et,
                              input int plen, input logic tuser,
                              input logic af, input bit fwd, input int ovf_at,
                              input int gap_at, input int rst_at,
                              input logic [7:0] seed);
        int          len, nw, rem, nout, cnt;
        logic [73:0] e;
        len = 14 + plen;
        for (int j = 0; j < 6; j++) fr[j] = dst[8*(5-j) +: 8];
        for (int j = 6; j < 12; j++) fr[j] = 8'hA0 + 8'(j);
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        for (int i = 0; i < plen; i++) fr[14+i] = seed + 8'(i);
        nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            if (w == gap_at) begin
                tick();
                rx_tvalid = 1'b0;
            end
            tick();
            if (w == rst_at) begin
                check("pre_rst_wr_en", {73'b0, wr_en}, 74'd1);
                sys_rst_n = 1'b0;
                rx_tvalid = 1'b0;
                full      = 1'b0;
                #1;
                check("rst_wr_en", {73'b0, wr_en}, 74'd0);
                check("rst_din", din, 74'd0);
                check("rst_ok_cnt", {42'b0, rx_ok_cnt}, 74'd0);
                check("rst_drop_cnt", {42'b0, rx_drop_cnt}, 74'd0);
                check("rst_ovf_cnt", {42'b0, rx_ovf_cnt}, 74'd0);
                tick();
                sys_rst_n = 1'b1;
                exp_ok = 0; exp_drop = 0; exp_ovf = 0;
                q_got.delete();
                q_exp.delete();
                return;
            end
            rem         = len - 8*w;
            rx_tvalid   = 1'b1;
            rx_tlast    = (w == nw - 1);
            rx_tkeep    = kmask(rem > 8 ? 8 : rem);
            rx_tuser    = (w == nw - 1) ? tuser : 1'b0;
            almost_full = af;
            full        = (ovf_at >= 0) && ((w == ovf_at) || (w == ovf_at + 1));
            for (int j = 0; j < 8; j++)
                rx_tdata[8*j +: 8] = (8*w + j < len) ? fr[8*w + j] : 8'h00;
        end
        if (fwd) begin
            exp_ok++;
            nout = (plen + 7) / 8;
            for (int i = 0; i < nout; i++) begin
                // Input word w is written while word w+1 is presented, so
                // full on words a, a+1 loses output words a-3 and a-2.
                if ((ovf_at >= 0) && ((i == ovf_at - 3) || (i == ovf_at - 2))) begin
                    exp_ovf++;
                    continue;
                end
                cnt = plen - 8*i;
                if (cnt > 8) cnt = 8;
                e = '0;
                for (int j = 0; j < cnt; j++) e[8*j +: 8] = fr[14 + 8*i + j];
                e[71:64] = kmask(cnt);
                e[72]    = (i == nout - 1);
                e[73]    = (i == nout - 1) && tuser && (ovf_at < 0);
                q_exp.push_back(e);
            end
        end else begin
            exp_drop++;
        end
    endtask

    task automatic check_writes(input string tag);
        int          n;
        logic [73:0] g;
        check({tag, "_nwr"}, 74'(q_got.size()), 74'(q_exp.size()));
        n = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
        for (int i = 0; i < n; i++) begin
            g = q_got[i];
            for (int j = 0; j < 8; j++) if (!g[64+j]) g[8*j +: 8] = 8'h00;
            check($sformatf("%s_w%0d", tag, i), g, q_exp[i]);
        end
        check({tag, "_ok_cnt"},   {42'b0, rx_ok_cnt},   74'(exp_ok));
        check({tag, "_drop_cnt"}, {42'b0, rx_drop_cnt}, 74'(exp_drop));
        check({tag, "_ovf_cnt"},  {42'b0, rx_ovf_cnt},  74'(exp_ovf));
        q_got.delete();
        q_exp.delete();
    endtask

    initial begin
        exp_ok = 0; exp_drop = 0; exp_ovf = 0;
        rx_tvalid = 1'b0; rx_tdata = 64'h0; rx_tkeep = 8'h00;
        rx_tlast = 1'b0; rx_tuser = 1'b0; full = 1'b0; almost_full = 1'b0;
        sys_rst_n = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        repeat (3) tick();
        check("init_wr_en", {73'b0, wr_en}, 74'd0);
        check("init_din", din, 74'd0);
        check("init_ok_cnt", {42'b0, rx_ok_cnt}, 74'd0);
        sys_rst_n = 1'b1;
        idle(2);

        // 64-byte frame: 6 full words plus a 2-byte FLUSH word.
        send_frame(C_MY_MAC, C_ETYPE, 50, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'h00);
        idle(3); check_writes("f64");
        // 36-byte frame with bad FCS, tail keep 3F, no FLUSH.
        send_frame(C_MY_MAC, C_ETYPE, 22, 1'b0, 1'b0, 1'b1, -1, -1, -1, 8'h40);
        idle(3); check_writes("f36_badfcs");
        send_frame(C_MY_MAC, 16'h0800, 50, 1'b1, 1'b0, 1'b0, -1, -1, -1, 8'h10);
        idle(3); check_writes("etype_ip");
        send_frame(48'h00_11_22_33_44_66, C_ETYPE, 50, 1'b1, 1'b0, 1'b0, -1, -1, -1, 8'h20);
        idle(3); check_writes("dst_miss");
        send_frame(C_BCAST, C_ETYPE, 30, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'h30);
        idle(3); check_writes("bcast");
        check("nb_bcast_drop", {42'b0, nb_drop_cnt}, 74'(exp_drop + 1));
        check("nb_bcast_ok",   {42'b0, nb_ok_cnt},   74'(exp_ok - 1));
        send_frame(C_MY_MAC, C_ETYPE, 50, 1'b1, 1'b1, 1'b0, -1, -1, -1, 8'h50);
        idle(3); check_writes("almost_full");
        // Header only: accepted but nothing to write.
        send_frame(C_MY_MAC, C_ETYPE, 0, 1'b1, 1'b0, 1'b0, -1, -1, -1, 8'h60);
        idle(3); check_writes("hdr_only");
        send_frame(C_MY_MAC, C_ETYPE, 1, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'h70);
        idle(3); check_writes("one_byte");
        // Back-to-back with the minimum gap, both ending in FLUSH.
        send_frame(C_MY_MAC, C_ETYPE, 50, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'h80);
        idle(2);
        send_frame(C_MY_MAC, C_ETYPE, 49, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'h90);
        idle(3); check_writes("b2b");
        send_frame(C_MY_MAC, C_ETYPE, 30, 1'b1, 1'b0, 1'b1, -1, 3, -1, 8'hA0);
        idle(3); check_writes("midgap");
        send_frame(C_MY_MAC, C_ETYPE, 50, 1'b1, 1'b0, 1'b1, 3, -1, -1, 8'hB0);
        idle(3); check_writes("ovf");
        check("no_wr_when_full", 74'(viol), 74'd0);

        // Reset while word 3 of an accepted frame is due.
        send_frame(C_MY_MAC, C_ETYPE, 50, 1'b1, 1'b0, 1'b1, -1, -1, 3, 8'hC0);
        idle(3); check_writes("post_rst");
        send_frame(C_MY_MAC, C_ETYPE, 22, 1'b1, 1'b0, 1'b1, -1, -1, -1, 8'hD0);
        idle(3); check_writes("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_decap.md
Name: eth_rx_decap

Overview:
- Receive-side counterpart of the PCIe-to-Ethernet path.
- Consumes the 10G MAC receive AXI-Stream (m_axis_rx_* of the MAC, 64-bit, clk156 domain) and filters frames on destination MAC and EtherType.
- Strips the 14-byte Ethernet header and realigns the payload to byte 0.
- Writes payload words into the write side of an eth-to-PCIe async FIFO using the same 74-bit word format as pcie2eth_fifo.

Parameters:
- MY_MAC, 48'h00_11_22_33_44_55: accepted unicast destination; byte 0 on wire = MY_MAC[47:40].
- ETHERTYPE, 16'h88B5: accepted EtherType, network order.
- ACCEPT_BCAST, 1'b1: also accept destination FF:FF:FF:FF:FF:FF.

Ports:
- clk156  in  1  core clock, 156.25 MHz.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_rx_tvalid  in  1  MAC rx valid. No tready: the MAC cannot be back-pressured.
- s_axis_rx_tdata  in  64  rx data; byte 0 = tdata[7:0] = first on wire.
- s_axis_rx_tkeep  in  8  byte enables, contiguous from LSB.
- s_axis_rx_tlast  in  1  last word of frame.
- s_axis_rx_tuser  in  1  on last word: 1 = good FCS, 0 = bad.
- full  in  1  FIFO full.
- almost_full  in  1  FIFO programmable full; threshold leaves room for at least one maximum frame (190 words).
- wr_en  out  1  FIFO write strobe.
- din  out  74  [63:0] data, [71:64] keep, [72] last, [73] user (1 = good frame).
- rx_ok_cnt  out  32  frames forwarded.
- rx_drop_cnt  out  32  frames filtered or refused.
- rx_ovf_cnt  out  32  words lost to full.

Behaviour:
- Reset values: wr_en=0, din=0, all counters=0, state=IDLE. Reset mid-frame aborts the frame with no write and no count; the next frame is handled normally.
- The MAC guarantees at least 2 idle cycles between frames. The FLUSH cycle relies on this.
- Counters wrap modulo 2^32.
- Word mapping:
  - Input word 0 = dst[0:5], src[0:1].
  - Input word 1 = src[2:5], then EtherType high byte in byte 4 and low byte in byte 5, then payload bytes 0-1 in bytes 6-7.
  - Output word k = {in(k+2)[47:0], in(k+1)[63:48]}. Register prev[63:48] of each input word for this.
- States:
  - IDLE: on a valid word, latch dst_ok = (dst==MY_MAC) | (ACCEPT_BCAST & dst==all-ones). If tlast, count a drop and stay in IDLE; otherwise go to HDR1.
  - HDR1: accept = dst_ok & EtherType==ETHERTYPE & !almost_full.
    - Not accepted: drop counter +1; go to DISCARD, or to IDLE if tlast.
    - Accepted with tlast and n=popcount(keep): if n<=6, no payload, drop +1, go to IDLE. If n>6, write one word with keep=(1<<(n-6))-1, last=1, user=tuser, ok +1, go to IDLE.
    - Accepted without tlast: go to PAYLOAD.
  - PAYLOAD: each valid word writes the realigned word with keep=FF, on the next cycle (registered output).
    - On tlast with n<=6: write keep=(1<<(n+2))-1, last=1, user=tuser, ok +1, go to IDLE.
    - On tlast with n>6: write a full word (last=0), latch tuser, go to FLUSH.
  - FLUSH: one cycle, no input consumed. Write {48'b0, prev[63:48]} with keep=(1<<(n-6))-1, last=1, user=latched tuser. ok +1, go to IDLE.
  - DISCARD: ignore words until tlast, then go to IDLE.
- Latency: the output for input word k+2 is registered one cycle after that word is accepted.
- Gaps: tvalid=0 mid-frame stalls the FSM without writing.
- Overflow: if full=1 on a write cycle, suppress the write, set ovf_flag and increment rx_ovf_cnt. While ovf_flag is set, the final word of the frame is written with user=0, if not itself blocked. The frame still counts as ok.
- Bad FCS: user=0 is forwarded on the final word. Downstream discards; this block still counts the frame ok.
- wr_en is never asserted when full=1.

Decomposition:
- Package eth_rx_pkg holds:
  - typedef fifo_word_t, a packed struct {user, last, keep[7:0], data[63:0]} = 74 bits;
  - enum state_t {IDLE, HDR1, PAYLOAD, FLUSH, DISCARD};
  - constants BCAST_MAC and HDR_BYTES=14;
  - function keep_lsb(n).
- Sub-module eth_rx_hdr_match: combinational dst/EtherType compare plus the registered dst_ok. The FSM, realign and counters stay in the top.

Test Plan:
- 64-byte frame, dst=MY_MAC, EtherType 88B5, 8 words, last keep FF, tuser=1 -> 7 writes: 6 with keep FF, final keep 03 last=1 user=1. Payload bytes 0..49 match. rx_ok_cnt=1.
- 36-byte frame, last word 4 with keep 0F -> 3 writes, final keep 3F last=1. 22 payload bytes correct. No FLUSH cycle.
- EtherType 0800 or dst mismatch -> zero writes, rx_drop_cnt=1. Broadcast dst with ACCEPT_BCAST=1 -> accepted; with 0 -> dropped.
- almost_full=1 during HDR1 -> frame dropped whole, rx_drop_cnt +1. Back-to-back frames with a 2-cycle gap, second one ending in FLUSH -> both forwarded intact.
- full=1 for 2 cycles mid-payload -> rx_ovf_cnt=2, final word user=0. tuser=0 on last -> final din user=0.
- Assert sys_rst_n=0 at word 3 of an accepted frame -> wr_en=0 and din=0 immediately, counters=0. Next frame is forwarded correctly.
